// File: rtl/nf_hazard_pkg.sv
// rtl/nf_hazard_pkg.sv - shared bypass codes and data-memory FSM states for the hazard unit
package nf_hazard_pkg;

  localparam logic [1:0] HU_BP_NONE = 2'd0;
  localparam logic [1:0] HU_BP_MEM  = 2'd1;
  localparam logic [1:0] HU_BP_WB   = 2'd2;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_ERR  = 2'd2
  } dm_state_e;

endpackage

// File: rtl/nf_hazard_unit_sb_if.sv
// rtl/nf_hazard_unit_sb_if.sv - pipeline-side bundle between the core and the hazard unit
interface nf_hazard_unit_sb_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);
  logic [RA_W-1:0]  ra1_id, ra2_id;
  logic             branch_id;
  logic [RA_W-1:0]  ra1_iexe, ra2_iexe;
  logic [RA_W-1:0]  wa3_iexe, wa3_imem, wa3_iwb;
  logic             we_rf_iexe, we_rf_imem, we_rf_iwb;
  logic             rf_src_iexe, rf_src_imem;
  logic             ll_iexe, ll_done;
  logic             req_dm, req_ack_dm;
  logic             branch_taken_iexe;
  logic [1:0]       rd1_bypass, rd2_bypass;
  logic             cmp_d1_bypass, cmp_d2_bypass;
  logic             stall_if, stall_id, stall_iexe, stall_imem, stall_iwb;
  logic             flush_id, flush_iexe, flush_imem;
  logic             dm_timeout;
  logic             sb_full;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ra1_id, ra2_id, branch_id, ra1_iexe, ra2_iexe,
           wa3_iexe, wa3_imem, wa3_iwb, we_rf_iexe, we_rf_imem, we_rf_iwb,
           rf_src_iexe, rf_src_imem, ll_iexe, ll_done, req_dm, req_ack_dm,
           branch_taken_iexe,
    input  rd1_bypass, rd2_bypass, cmp_d1_bypass, cmp_d2_bypass,
           stall_if, stall_id, stall_iexe, stall_imem, stall_iwb,
           flush_id, flush_iexe, flush_imem, dm_timeout, sb_full, stall_cnt
  );

  modport slave (
    input  ra1_id, ra2_id, branch_id, ra1_iexe, ra2_iexe,
           wa3_iexe, wa3_imem, wa3_iwb, we_rf_iexe, we_rf_imem, we_rf_iwb,
           rf_src_iexe, rf_src_imem, ll_iexe, ll_done, req_dm, req_ack_dm,
           branch_taken_iexe,
    output rd1_bypass, rd2_bypass, cmp_d1_bypass, cmp_d2_bypass,
           stall_if, stall_id, stall_iexe, stall_imem, stall_iwb,
           flush_id, flush_iexe, flush_imem, dm_timeout, sb_full, stall_cnt
  );
endinterface

// File: rtl/nf_ll_scoreboard.sv
// rtl/nf_ll_scoreboard.sv - in-order FIFO of pending long-latency destination registers
module nf_ll_scoreboard #(
  parameter int LL_DEPTH = 4,
  parameter int RA_W     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [RA_W-1:0] push_addr,
  input  logic            pop,
  input  logic [RA_W-1:0] q1,
  input  logic [RA_W-1:0] q2,
  output logic            hit1,
  output logic            hit2,
  output logic            full
);
  localparam int PW = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
  localparam int CW = $clog2(LL_DEPTH + 1);
  localparam logic [PW-1:0] LAST  = PW'(LL_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH = CW'(LL_DEPTH);

  logic [RA_W-1:0]     mem [LL_DEPTH];
  logic [LL_DEPTH-1:0] vld;
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;
  logic                pop_eff, push_eff;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign pop_eff  = pop && (count != '0);
  assign push_eff = push && ((count != DEPTH) || pop_eff);
  assign full     = (count == DEPTH);

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_addr;
  end

  // Clear before set: a same-cycle push into the slot just popped keeps it valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (pop_eff) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= ptr_next(rd_ptr);
      end
      if (push_eff) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (push_eff && !pop_eff)      count <= count + 1'b1;
      else if (pop_eff && !push_eff) count <= count - 1'b1;
    end
  end

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < LL_DEPTH; i++) begin
      if (vld[i] && (q1 != '0) && (mem[i] == q1)) hit1 = 1'b1;
      if (vld[i] && (q2 != '0) && (mem[i] == q2)) hit2 = 1'b1;
    end
  end
endmodule

// File: rtl/nf_hazard_unit_sb.sv
// rtl/nf_hazard_unit_sb.sv - forwarding, stall/flush control, LL scoreboard and data-memory watchdog
module nf_hazard_unit_sb
  import nf_hazard_pkg::*;
#(
  parameter int RA_W       = 5,
  parameter int LL_DEPTH   = 4,
  parameter int DM_TIMEOUT = 16,
  parameter int CNT_W      = 32
) (
  input logic             clk,
  input logic             rst,
  nf_hazard_unit_sb_if.slave hu
);
  localparam int WW = $clog2(DM_TIMEOUT);

  function automatic logic rf_match(input logic [RA_W-1:0] src,
                                    input logic [RA_W-1:0] dst,
                                    input logic            we);
    return we && (src != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] bp_sel(input logic m, input logic w);
    return m ? HU_BP_MEM : (w ? HU_BP_WB : HU_BP_NONE);
  endfunction

  dm_state_e        state;
  logic [WW-1:0]    wcnt;
  logic [CNT_W-1:0] cnt;
  logic sb_hit1, sb_hit2, sb_full, sb_push;
  logic id_ex, id_mem, mem_stall, lw_stall, br_stall, sb_stall, full_stall;
  logic s_if, s_id, s_ex, s_mem, s_wb, f_id, f_ex, f_mem;

  assign hu.rd1_bypass = bp_sel(rf_match(hu.ra1_iexe, hu.wa3_imem, hu.we_rf_imem),
                                rf_match(hu.ra1_iexe, hu.wa3_iwb,  hu.we_rf_iwb));
  assign hu.rd2_bypass = bp_sel(rf_match(hu.ra2_iexe, hu.wa3_imem, hu.we_rf_imem),
                                rf_match(hu.ra2_iexe, hu.wa3_iwb,  hu.we_rf_iwb));
  assign hu.cmp_d1_bypass = rf_match(hu.ra1_id, hu.wa3_imem, hu.we_rf_imem);
  assign hu.cmp_d2_bypass = rf_match(hu.ra2_id, hu.wa3_imem, hu.we_rf_imem);

  assign id_ex  = rf_match(hu.ra1_id, hu.wa3_iexe, hu.we_rf_iexe) ||
                  rf_match(hu.ra2_id, hu.wa3_iexe, hu.we_rf_iexe);
  assign id_mem = rf_match(hu.ra1_id, hu.wa3_imem, hu.we_rf_imem) ||
                  rf_match(hu.ra2_id, hu.wa3_imem, hu.we_rf_imem);

  assign lw_stall   = id_ex && hu.rf_src_iexe;
  assign br_stall   = hu.branch_id && (id_ex || (id_mem && hu.rf_src_imem));
  assign sb_stall   = sb_hit1 || sb_hit2;
  assign full_stall = hu.ll_iexe && sb_full && !hu.ll_done;
  assign mem_stall  = hu.req_dm && !hu.req_ack_dm && (state != DM_ERR);

  // A taken branch outranks data hazards since the stalled instructions are wrong-path anyway.
  always_comb begin
    {s_if, s_id, s_ex, s_mem, s_wb, f_id, f_ex, f_mem} = '0;
    if (mem_stall) begin
      {s_if, s_id, s_ex, s_mem, s_wb} = '1;
    end else if (hu.branch_taken_iexe) begin
      f_id = 1'b1;
      f_ex = 1'b1;
    end else if (full_stall) begin
      {s_if, s_id, s_ex} = '1;
      f_mem = 1'b1;
    end else if (lw_stall || br_stall || sb_stall) begin
      s_if = 1'b1;
      s_id = 1'b1;
      f_ex = 1'b1;
    end
  end

  assign hu.stall_if   = s_if;
  assign hu.stall_id   = s_id;
  assign hu.stall_iexe = s_ex;
  assign hu.stall_imem = s_mem;
  assign hu.stall_iwb  = s_wb;
  assign hu.flush_id   = f_id;
  assign hu.flush_iexe = f_ex;
  assign hu.flush_imem = f_mem;
  assign hu.sb_full    = sb_full;
  assign hu.dm_timeout = (state == DM_ERR);
  assign hu.stall_cnt  = cnt;

  assign sb_push = hu.ll_iexe && hu.we_rf_iexe && (hu.wa3_iexe != '0) && !s_ex && !full_stall;

  nf_ll_scoreboard #(.LL_DEPTH(LL_DEPTH), .RA_W(RA_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .push      (sb_push),
    .push_addr (hu.wa3_iexe),
    .pop       (hu.ll_done),
    .q1        (hu.ra1_id),
    .q2        (hu.ra2_id),
    .hit1      (sb_hit1),
    .hit2      (sb_hit2),
    .full      (sb_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DM_IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        DM_IDLE: if (hu.req_dm && !hu.req_ack_dm) begin
          state <= DM_WAIT;
          wcnt  <= WW'(1);
        end
        DM_WAIT: begin
          if (hu.req_ack_dm || !hu.req_dm)          state <= DM_IDLE;
          else if (wcnt == WW'(DM_TIMEOUT - 1))     state <= DM_ERR;
          else                                      wcnt  <= wcnt + 1'b1;
        end
        DM_ERR:  state <= DM_IDLE;
        default: state <= DM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (s_if && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_nf_hazard_unit_sb.sv
// tb/tb_nf_hazard_unit_sb.sv - vector table, directed corner sequences and random run against a reference model
module tb_nf_hazard_unit_sb;
  localparam int RA_W = 5, LL_DEPTH = 4, DM_TIMEOUT = 16, CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [RA_W-1:0] ra1_id, ra2_id;
    logic            branch_id;
    logic [RA_W-1:0] ra1_iexe, ra2_iexe, wa3_iexe, wa3_imem, wa3_iwb;
    logic            we_ex, we_mem, we_wb, rf_src_ex, rf_src_mem;
    logic            ll_iexe, ll_done, req_dm, ack, br_taken;
  } in_t;

  typedef struct packed {
    logic [1:0] rd1, rd2;
    logic       cmp1, cmp2, s_if, s_id, s_ex, s_mem, s_wb, f_id, f_ex, f_mem, tmo, full;
  } out_t;

  typedef struct {
    string name;
    in_t   v;
    out_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nf_hazard_unit_sb_if #(.RA_W(RA_W), .CNT_W(CNT_W)) hu ();
  nf_hazard_unit_sb #(.RA_W(RA_W), .LL_DEPTH(LL_DEPTH), .DM_TIMEOUT(DM_TIMEOUT), .CNT_W(CNT_W))
    dut (.clk(clk), .rst(rst), .hu(hu.slave));

  int   checks = 0, errors = 0;
  int   m_sb[$];
  int   m_age, m_cnt;
  bit   m_err;
  out_t last_out;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit mt(input int a, input int w, input bit we);
    return we && a != 0 && a == w;
  endfunction

  function automatic out_t model_out(input in_t v);
    out_t o = '0;
    bit full = (m_sb.size() == LL_DEPTH);
    bit sbh = 0, lw, br, fs, ms;
    foreach (m_sb[i]) if (m_sb[i] == int'(v.ra1_id) || m_sb[i] == int'(v.ra2_id)) sbh = 1;
    lw = (mt(v.ra1_id, v.wa3_iexe, v.we_ex) || mt(v.ra2_id, v.wa3_iexe, v.we_ex)) && v.rf_src_ex;
    br = v.branch_id && (mt(v.ra1_id, v.wa3_iexe, v.we_ex) || mt(v.ra2_id, v.wa3_iexe, v.we_ex) ||
         ((mt(v.ra1_id, v.wa3_imem, v.we_mem) || mt(v.ra2_id, v.wa3_imem, v.we_mem)) && v.rf_src_mem));
    fs = v.ll_iexe && full && !v.ll_done;
    ms = v.req_dm && !v.ack && !m_err;
    o.rd1 = mt(v.ra1_iexe, v.wa3_imem, v.we_mem) ? 2'd1 : mt(v.ra1_iexe, v.wa3_iwb, v.we_wb) ? 2'd2 : 2'd0;
    o.rd2 = mt(v.ra2_iexe, v.wa3_imem, v.we_mem) ? 2'd1 : mt(v.ra2_iexe, v.wa3_iwb, v.we_wb) ? 2'd2 : 2'd0;
    o.cmp1 = mt(v.ra1_id, v.wa3_imem, v.we_mem);
    o.cmp2 = mt(v.ra2_id, v.wa3_imem, v.we_mem);
    if (ms) {o.s_if, o.s_id, o.s_ex, o.s_mem, o.s_wb} = 5'b11111;
    else if (v.br_taken) {o.f_id, o.f_ex} = 2'b11;
    else if (fs) {o.s_if, o.s_id, o.s_ex, o.f_mem} = 4'b1111;
    else if (lw || br || sbh) {o.s_if, o.s_id, o.f_ex} = 3'b111;
    o.tmo  = m_err;
    o.full = full;
    return o;
  endfunction

  task automatic model_tick(input in_t v, input out_t e);
    bit full = (m_sb.size() == LL_DEPTH);
    bit fs = v.ll_iexe && full && !v.ll_done;
    if (e.s_if && m_cnt < CNT_MAX) m_cnt++;
    if (v.ll_done && m_sb.size() > 0) void'(m_sb.pop_front());
    if (v.ll_iexe && v.we_ex && v.wa3_iexe != 0 && !e.s_ex && !fs) m_sb.push_back(int'(v.wa3_iexe));
    // Streak of unacknowledged request cycles; the DM_TIMEOUT-th one triggers a one-cycle error.
    if (m_err) begin
      m_err = 0;
      m_age = 0;
    end else if (v.req_dm && !v.ack) begin
      m_age++;
      if (m_age == DM_TIMEOUT) begin
        m_err = 1;
        m_age = 0;
      end
    end else m_age = 0;
  endtask

  task automatic drive(input in_t v);
    hu.ra1_id = v.ra1_id;       hu.ra2_id = v.ra2_id;       hu.branch_id = v.branch_id;
    hu.ra1_iexe = v.ra1_iexe;   hu.ra2_iexe = v.ra2_iexe;   hu.wa3_iexe = v.wa3_iexe;
    hu.wa3_imem = v.wa3_imem;   hu.wa3_iwb = v.wa3_iwb;
    hu.we_rf_iexe = v.we_ex;    hu.we_rf_imem = v.we_mem;   hu.we_rf_iwb = v.we_wb;
    hu.rf_src_iexe = v.rf_src_ex; hu.rf_src_imem = v.rf_src_mem;
    hu.ll_iexe = v.ll_iexe;     hu.ll_done = v.ll_done;
    hu.req_dm = v.req_dm;       hu.req_ack_dm = v.ack;      hu.branch_taken_iexe = v.br_taken;
  endtask

  function automatic out_t get_out();
    return {hu.rd1_bypass, hu.rd2_bypass, hu.cmp_d1_bypass, hu.cmp_d2_bypass,
            hu.stall_if, hu.stall_id, hu.stall_iexe, hu.stall_imem, hu.stall_iwb,
            hu.flush_id, hu.flush_iexe, hu.flush_imem, hu.dm_timeout, hu.sb_full};
  endfunction

  task automatic step(input in_t v);
    out_t e;
    drive(v);
    @(negedge clk);
    e = model_out(v);
    last_out = get_out();
    chk("model_out", 32'(last_out), 32'(e));
    chk("stall_cnt", 32'(hu.stall_cnt), 32'(m_cnt));
    @(posedge clk);
    model_tick(v, e);
    #1;
  endtask

  task automatic do_rst(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    m_sb.delete();
    m_age = 0; m_err = 0; m_cnt = 0;
    #1 rst = 1'b0;
  endtask

  task automatic add(input string n, input in_t v, input out_t e);
    vec_t t;
    t.name = n; t.v = v; t.e = e;
    tbl.push_back(t);
  endtask

  initial begin
    in_t v;
    out_t e;
    bit rq;

    // Combinational vectors, all applied from an empty scoreboard with the FSM idle.
    v = '0; e = '0; add("idle", v, e);
    v = '0; v.ra1_iexe = 5; v.wa3_imem = 5; v.we_mem = 1; v.wa3_iwb = 5; v.we_wb = 1;
    e = '0; e.rd1 = 2'd1; add("fwd_mem_prio", v, e);
    v = '0; v.we_mem = 1; v.we_wb = 1; e = '0; add("fwd_x0", v, e);
    v = '0; v.ra2_iexe = 6; v.wa3_iwb = 6; v.we_wb = 1; e = '0; e.rd2 = 2'd2; add("fwd_wb", v, e);
    v = '0; v.ra1_iexe = 4; v.wa3_imem = 4; v.wa3_iwb = 4; v.we_wb = 1;
    e = '0; e.rd1 = 2'd2; add("fwd_mem_no_we", v, e);
    v = '0; v.ra1_id = 3; v.wa3_iexe = 3; v.we_ex = 1; v.rf_src_ex = 1;
    e = '0; e.s_if = 1; e.s_id = 1; e.f_ex = 1; add("load_use", v, e);
    v = '0; v.we_ex = 1; v.rf_src_ex = 1; e = '0; add("load_use_x0", v, e);
    v = '0; v.ra1_id = 3; v.wa3_iexe = 3; v.we_ex = 1; e = '0; add("alu_no_stall", v, e);
    v = '0; v.branch_id = 1; v.ra2_id = 9; v.wa3_iexe = 9; v.we_ex = 1;
    e = '0; e.s_if = 1; e.s_id = 1; e.f_ex = 1; add("br_exe", v, e);
    v = '0; v.branch_id = 1; v.ra1_id = 12; v.wa3_imem = 12; v.we_mem = 1; v.rf_src_mem = 1;
    e = '0; e.cmp1 = 1; e.s_if = 1; e.s_id = 1; e.f_ex = 1; add("br_mem_load", v, e);
    v = '0; v.branch_id = 1; v.ra2_id = 12; v.wa3_imem = 12; v.we_mem = 1;
    e = '0; e.cmp2 = 1; add("br_mem_alu", v, e);
    v = '0; v.ra1_id = 3; v.wa3_iexe = 3; v.we_ex = 1; v.rf_src_ex = 1; v.br_taken = 1;
    e = '0; e.f_id = 1; e.f_ex = 1; add("branch_over_lw", v, e);
    v.req_dm = 1; e = '0; {e.s_if, e.s_id, e.s_ex, e.s_mem, e.s_wb} = '1; add("mem_over_branch", v, e);
    v = '0; e = '0; add("req_drop", v, e);
    v = '0; v.req_dm = 1; v.ack = 1; e = '0; add("req_ack_same", v, e);

    drive('0);
    do_rst(2);
    chk("rst_stall_cnt", 32'(hu.stall_cnt), 0);
    chk("rst_sb_full", 32'(hu.sb_full), 0);
    chk("rst_dm_timeout", 32'(hu.dm_timeout), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v);
      chk(tbl[i].name, 32'(last_out), 32'(tbl[i].e));
    end

    // Scoreboard fill, full stall, pop-release and push/pop at full.
    do_rst(1);
    for (int k = 7; k <= 10; k++) begin
      v = '0; v.ll_iexe = 1; v.we_ex = 1; v.wa3_iexe = RA_W'(k); step(v);
    end
    chk("sb_full_4", 32'(hu.sb_full), 1);
    v = '0; v.ll_iexe = 1; v.we_ex = 1; v.wa3_iexe = 11; step(v);
    chk("full_stall", 32'({last_out.s_if, last_out.s_id, last_out.s_ex, last_out.s_mem, last_out.f_mem}), 32'b11101);
    v = '0; v.ra1_id = 7; step(v);
    chk("sb_stall_x7", 32'(last_out.s_if), 1);
    v.ll_done = 1; step(v);
    chk("sb_stall_pop_cycle", 32'(last_out.s_if), 1);
    v.ll_done = 0; step(v);
    chk("sb_release_x7", 32'(last_out.s_if), 0);
    chk("sb_not_full", 32'(last_out.full), 0);
    v = '0; v.ll_iexe = 1; v.we_ex = 1; v.wa3_iexe = 11; step(v);
    chk("sb_full_again", 32'(hu.sb_full), 1);
    v.wa3_iexe = 12; v.ll_done = 1; step(v);
    chk("push_pop_no_stall", 32'(last_out.s_if), 0);
    chk("push_pop_full", 32'(hu.sb_full), 1);
    v = '0; v.ra2_id = 8; step(v);
    chk("x8_popped", 32'(last_out.s_if), 0);
    v.ra2_id = 9; step(v);
    chk("x9_pending", 32'(last_out.s_if), 1);

    // Memory timeout: 16 stalled cycles (the idle one plus 15 waiting), pulse, then a fresh wait.
    do_rst(1);
    for (int i = 0; i < 20; i++) begin
      v = '0; v.req_dm = 1; step(v);
      chk($sformatf("tmo_stall_%0d", i), 32'(last_out.s_wb), 32'(i != 16));
      chk($sformatf("tmo_pulse_%0d", i), 32'(last_out.tmo), 32'(i == 16));
    end
    v = '0; step(v);
    for (int i = 0; i < 7; i++) begin
      v = '0; v.req_dm = (i < 4); v.ack = (i == 3); step(v);
      chk($sformatf("ack_stall_%0d", i), 32'(last_out.s_if), 32'(i < 3));
      chk($sformatf("ack_no_pulse_%0d", i), 32'(last_out.tmo), 0);
    end

    // Reset during a wait with three scoreboard entries.
    do_rst(1);
    for (int k = 1; k <= 3; k++) begin
      v = '0; v.ll_iexe = 1; v.we_ex = 1; v.wa3_iexe = RA_W'(k); step(v);
    end
    v = '0; v.req_dm = 1; step(v); step(v);
    do_rst(1);
    chk("rst_mid_cnt", 32'(hu.stall_cnt), 0);
    chk("rst_mid_full", 32'(hu.sb_full), 0);
    v = '0; v.ra1_id = 1; v.ra2_id = 3; step(v);
    chk("rst_mid_sb_empty", 32'(last_out.s_if), 0);

    // Saturation of the stall counter.
    for (int i = 0; i < 40; i++) begin
      v = '0; v.req_dm = 1; step(v);
    end
    chk("stall_cnt_sat", 32'(hu.stall_cnt), CNT_MAX);

    // Random run against the model.
    do_rst(1);
    rq = 0;
    for (int i = 0; i < 1500; i++) begin
      v = '0;
      v.ra1_id = RA_W'($urandom_range(0, 3));   v.ra2_id = RA_W'($urandom_range(0, 3));
      v.ra1_iexe = RA_W'($urandom_range(0, 3)); v.ra2_iexe = RA_W'($urandom_range(0, 3));
      v.wa3_iexe = RA_W'($urandom_range(0, 3)); v.wa3_imem = RA_W'($urandom_range(0, 3));
      v.wa3_iwb = RA_W'($urandom_range(0, 3));
      v.branch_id = ($urandom_range(0, 3) == 0);
      v.we_ex = $urandom_range(0, 1); v.we_mem = $urandom_range(0, 1); v.we_wb = $urandom_range(0, 1);
      v.rf_src_ex = ($urandom_range(0, 3) == 0); v.rf_src_mem = ($urandom_range(0, 3) == 0);
      v.ll_iexe = ($urandom_range(0, 2) == 0); v.ll_done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) rq = ~rq;
      v.req_dm = rq;
      v.ack = ($urandom_range(0, 11) == 0);
      v.br_taken = ($urandom_range(0, 9) == 0);
      step(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
